// File: rtl/cpu_module_mem_wb.sv
// MEM stage with EX/MEM and MEM/WB pipeline registers, req/ack data-memory port and stall counter.
// Optional alignment trap enabled by defining DMEM_ALIGN_CHECK_EN.
module cpu_module_mem_wb #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_ex,
    input  logic [REG_AW-1:0] RegWriteAddr_ex,
    input  logic [DATA_W-1:0] ALUResult_ex,
    input  logic [DATA_W-1:0] MemWriteData_ex,
    input  logic              RegWrite_ex,
    input  logic              MemRead_ex,
    input  logic              MemWrite_ex,
    input  logic              MemToReg_ex,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [REG_AW-1:0] RegWriteAddr_mem,
    output logic              RegWrite_mem,
    output logic [DATA_W-1:0] ALUResult_mem,
    output logic              MemRead_mem,
    output logic [REG_AW-1:0] RegWriteAddr_wb,
    output logic              RegWrite_wb,
    output logic [DATA_W-1:0] RegWriteData_wb,
    output logic              Stall_mem,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              align_err
);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t state_q, state_d;

    logic [REG_AW-1:0] rwaddr_mem_q, rwaddr_mem_d;
    logic [DATA_W-1:0] alu_mem_q, alu_mem_d;
    logic [DATA_W-1:0] wdata_mem_q, wdata_mem_d;
    logic              rw_mem_q, rw_mem_d;
    logic              mr_mem_q, mr_mem_d;
    logic              mw_mem_q, mw_mem_d;
    logic              m2r_mem_q, m2r_mem_d;

    logic [REG_AW-1:0] rwaddr_wb_q, rwaddr_wb_d;
    logic              rw_wb_q, rw_wb_d;
    logic [DATA_W-1:0] rwdata_wb_q, rwdata_wb_d;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic memop;
    logic misalign;
    logic req_ok;

    assign memop = mr_mem_q | mw_mem_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = memop & (alu_mem_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign req_ok    = memop & ~misalign;
    assign align_err = misalign;
    assign Stall_mem = dmem_req & ~dmem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (dmem_req & ~dmem_ack) state_d = ST_WAIT;
            ST_WAIT: if (dmem_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A pending access keeps the request up until ack; EX/MEM is frozen meanwhile.
    always_comb begin
        dmem_req = 1'b0;
        case (state_q)
            ST_IDLE: dmem_req = req_ok;
            ST_WAIT: dmem_req = 1'b1;
            default: dmem_req = 1'b0;
        endcase
    end

    assign dmem_we    = mw_mem_q;
    assign dmem_addr  = alu_mem_q;
    assign dmem_wdata = wdata_mem_q;

    always_comb begin
        rwaddr_mem_d = rwaddr_mem_q;
        alu_mem_d    = alu_mem_q;
        wdata_mem_d  = wdata_mem_q;
        rw_mem_d     = rw_mem_q;
        mr_mem_d     = mr_mem_q;
        mw_mem_d     = mw_mem_q;
        m2r_mem_d    = m2r_mem_q;
        rwaddr_wb_d  = rwaddr_wb_q;
        rw_wb_d      = rw_wb_q;
        rwdata_wb_d  = rwdata_wb_q;
        if (!Stall_mem) begin
            rwaddr_mem_d = RegWriteAddr_ex;
            alu_mem_d    = ALUResult_ex;
            wdata_mem_d  = MemWriteData_ex;
            rw_mem_d     = RegWrite_ex & valid_ex;
            mr_mem_d     = MemRead_ex & valid_ex;
            mw_mem_d     = MemWrite_ex & valid_ex;
            m2r_mem_d    = MemToReg_ex & valid_ex;
            rwaddr_wb_d  = rwaddr_mem_q;
            rw_wb_d      = rw_mem_q & ~misalign;
            rwdata_wb_d  = m2r_mem_q ? dmem_rdata : alu_mem_q;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall_mem && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rwaddr_mem_q <= '0;
            alu_mem_q    <= '0;
            wdata_mem_q  <= '0;
            rw_mem_q     <= 1'b0;
            mr_mem_q     <= 1'b0;
            mw_mem_q     <= 1'b0;
            m2r_mem_q    <= 1'b0;
            rwaddr_wb_q  <= '0;
            rw_wb_q      <= 1'b0;
            rwdata_wb_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            rwaddr_mem_q <= rwaddr_mem_d;
            alu_mem_q    <= alu_mem_d;
            wdata_mem_q  <= wdata_mem_d;
            rw_mem_q     <= rw_mem_d;
            mr_mem_q     <= mr_mem_d;
            mw_mem_q     <= mw_mem_d;
            m2r_mem_q    <= m2r_mem_d;
            rwaddr_wb_q  <= rwaddr_wb_d;
            rw_wb_q      <= rw_wb_d;
            rwdata_wb_q  <= rwdata_wb_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign RegWriteAddr_mem = rwaddr_mem_q;
    assign RegWrite_mem     = rw_mem_q;
    assign ALUResult_mem    = alu_mem_q;
    assign MemRead_mem      = mr_mem_q;
    assign RegWriteAddr_wb  = rwaddr_wb_q;
    assign RegWrite_wb      = rw_wb_q;
    assign RegWriteData_wb  = rwdata_wb_q;
    assign stall_cnt        = stall_cnt_q;

endmodule

// File: tb/tb_cpu_module_mem_wb.sv
// Scoreboard bench for cpu_module_mem_wb with a wait-state data-memory model.
module tb_cpu_module_mem_wb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          valid_ex;
    logic [AW-1:0] RegWriteAddr_ex;
    logic [DW-1:0] ALUResult_ex;
    logic [DW-1:0] MemWriteData_ex;
    logic          RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          dmem_ack;
    logic [AW-1:0] RegWriteAddr_mem;
    logic          RegWrite_mem;
    logic [DW-1:0] ALUResult_mem;
    logic          MemRead_mem;
    logic [AW-1:0] RegWriteAddr_wb;
    logic          RegWrite_wb;
    logic [DW-1:0] RegWriteData_wb;
    logic          Stall_mem;
    logic [CW-1:0] stall_cnt;
    logic          align_err;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    wb_t sb[$];
    int checks = 0;
    int errors = 0;
    int mem_wait = 0;
    int wait_cnt;
    int exp_stall = 0;
    logic [DW-1:0] mem_rdata = '0;

    cpu_module_mem_wb #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .valid_ex(valid_ex),
        .RegWriteAddr_ex(RegWriteAddr_ex), .ALUResult_ex(ALUResult_ex),
        .MemWriteData_ex(MemWriteData_ex), .RegWrite_ex(RegWrite_ex),
        .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .MemToReg_ex(MemToReg_ex),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .RegWriteAddr_mem(RegWriteAddr_mem), .RegWrite_mem(RegWrite_mem),
        .ALUResult_mem(ALUResult_mem), .MemRead_mem(MemRead_mem),
        .RegWriteAddr_wb(RegWriteAddr_wb), .RegWrite_wb(RegWrite_wb),
        .RegWriteData_wb(RegWriteData_wb), .Stall_mem(Stall_mem),
        .stall_cnt(stall_cnt), .align_err(align_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: acks after mem_wait cycles of an outstanding request.
    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (dmem_req && !dmem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign dmem_ack   = dmem_req && (wait_cnt == mem_wait);
    assign dmem_rdata = mem_rdata;

    task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                         input logic m2r, input logic [AW-1:0] ra, input logic [DW-1:0] alu,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd_exp);
        wb_t e;
        logic misal;
        logic [DW-1:0] a;
        valid_ex = v; RegWrite_ex = rw; MemRead_ex = mr; MemWrite_ex = mw; MemToReg_ex = m2r;
        RegWriteAddr_ex = ra; ALUResult_ex = alu; MemWriteData_ex = wd;
        a = alu;
        misal = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        misal = v & (mr | mw) & (a[1:0] != 2'b00);
`endif
        e.rw   = v & rw & ~misal;
        e.addr = ra;
        e.data = (v & m2r) ? rd_exp : alu;
        sb.push_back(e);
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
        checks++; if (Stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", Stall_mem); end
        checks++; if (RegWrite_wb !== 1'b0) begin errors++; $display("FAIL reset_rw_wb got=%b exp=0", RegWrite_wb); end
        checks++; if (RegWriteData_wb !== '0) begin errors++; $display("FAIL reset_data_wb got=%h exp=0", RegWriteData_wb); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_alu();
        wb_t e;
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h10, 32'h0, 32'h0);
        @(negedge clk); bubble();
        checks++; if (RegWrite_mem !== 1'b1) begin errors++; $display("FAIL alu_rw_mem got=%b exp=1", RegWrite_mem); end
        checks++; if (ALUResult_mem !== 32'h10) begin errors++; $display("FAIL alu_res_mem got=%h exp=10", ALUResult_mem); end
        checks++; if (RegWriteAddr_mem !== 5'd5) begin errors++; $display("FAIL alu_addr_mem got=%0d exp=5", RegWriteAddr_mem); end
        checks++; if (dmem_req !== 1'b0 || Stall_mem !== 1'b0) begin errors++; $display("FAIL alu_noreq got=%b%b exp=00", dmem_req, Stall_mem); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL alu_sb_empty got=0 exp=entry"); end
            else begin
                e = sb.pop_front();
                if (RegWrite_wb !== e.rw || RegWriteAddr_wb !== e.addr || RegWriteData_wb !== e.data) begin
                    errors++;
                    $display("FAIL alu_wb got=%b/%0d/%h exp=%b/%0d/%h", RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, e.rw, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_load_zero_wait();
        wb_t e;
        @(negedge clk); mem_wait = 0; mem_rdata = 32'hDEAD_BEEF;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h100, 32'h0, 32'hDEAD_BEEF);
        @(negedge clk); bubble();
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin errors++; $display("FAIL ld_req got=%b%b exp=10", dmem_req, dmem_we); end
        checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL ld_addr got=%h exp=100", dmem_addr); end
        checks++; if (Stall_mem !== 1'b0) begin errors++; $display("FAIL ld_stall got=%b exp=0", Stall_mem); end
        checks++; if (MemRead_mem !== 1'b1) begin errors++; $display("FAIL ld_memread got=%b exp=1", MemRead_mem); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL ld_sb_empty got=0 exp=entry"); end
            else begin
                e = sb.pop_front();
                if (RegWrite_wb !== e.rw || RegWriteAddr_wb !== e.addr || RegWriteData_wb !== e.data) begin
                    errors++;
                    $display("FAIL ld_wb got=%b/%0d/%h exp=%b/%0d/%h", RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, e.rw, e.addr, e.data);
                end
            end
        end
        checks++; if (stall_cnt !== CW'(exp_stall)) begin errors++; $display("FAIL ld_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_store_wait();
        wb_t e, held;
        int stalls;
        @(negedge clk); mem_wait = 3;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h77, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h200, 32'h1234_5678, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h33, 32'h0, 32'h0);
        held.rw = 1'b0; held.addr = '0; held.data = '0;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL st_sb_empty got=0 exp=entry"); end
        else begin
            held = sb.pop_front();
            if (RegWrite_wb !== held.rw || RegWriteAddr_wb !== held.addr || RegWriteData_wb !== held.data) begin
                errors++;
                $display("FAIL st_prev_wb got=%b/%0d/%h exp=%b/%0d/%h", RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, held.rw, held.addr, held.data);
            end
        end
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL st_req got=%b%b exp=11", dmem_req, dmem_we); end
        stalls = 0;
        while (Stall_mem === 1'b1 && stalls < 40) begin
            checks++;
            if (dmem_addr !== 32'h200 || dmem_wdata !== 32'h1234_5678 || dmem_req !== 1'b1) begin
                errors++; $display("FAIL st_stable got=%h/%h/%b exp=200/12345678/1", dmem_addr, dmem_wdata, dmem_req);
            end
            checks++;
            if (RegWrite_wb !== held.rw || RegWriteAddr_wb !== held.addr || RegWriteData_wb !== held.data) begin
                errors++; $display("FAIL st_wb_hold got=%b/%0d/%h exp=%b/%0d/%h", RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, held.rw, held.addr, held.data);
            end
            stalls++;
            @(negedge clk);
        end
        exp_stall = (exp_stall + 3 > 15) ? 15 : exp_stall + 3;
        checks++; if (stalls != 3) begin errors++; $display("FAIL st_stall_cycles got=%0d exp=3", stalls); end
        checks++; if (stall_cnt !== CW'(exp_stall)) begin errors++; $display("FAIL st_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
        @(negedge clk); bubble();
        checks++; if (RegWriteAddr_mem !== 5'd9 || ALUResult_mem !== 32'h33) begin errors++; $display("FAIL st_next_mem got=%0d/%h exp=9/33", RegWriteAddr_mem, ALUResult_mem); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL st_sb_empty got=0 exp=entry"); end
            else begin
                e = sb.pop_front();
                if (RegWrite_wb !== e.rw || RegWriteAddr_wb !== e.addr || RegWriteData_wb !== e.data) begin
                    errors++;
                    $display("FAIL st_wb got=%b/%0d/%h exp=%b/%0d/%h", RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, e.rw, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_bubble();
        wb_t e;
        @(negedge clk); mem_wait = 0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h500, 32'h0, 32'h0);
        @(negedge clk); bubble();
        checks++; if (RegWrite_mem !== 1'b0) begin errors++; $display("FAIL bub_rw_mem got=%b exp=0", RegWrite_mem); end
        checks++; if (dmem_req !== 1'b0 || MemRead_mem !== 1'b0) begin errors++; $display("FAIL bub_req got=%b/%b exp=0/0", dmem_req, MemRead_mem); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL bub_sb_empty got=0 exp=entry"); end
            else begin
                e = sb.pop_front();
                if (RegWrite_wb !== e.rw || RegWriteAddr_wb !== e.addr || RegWriteData_wb !== e.data) begin
                    errors++;
                    $display("FAIL bub_wb got=%b/%0d/%h exp=%b/%0d/%h", RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, e.rw, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_saturation();
        wb_t e;
        int stalls;
        @(negedge clk); mem_wait = 20; mem_rdata = 32'hCAFE_0001;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h40, 32'h0, 32'hCAFE_0001);
        @(negedge clk); bubble();
        stalls = 0;
        while (Stall_mem === 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        exp_stall = (exp_stall + 20 > 15) ? 15 : exp_stall + 20;
        checks++; if (stalls != 20) begin errors++; $display("FAIL sat_stall_cycles got=%0d exp=20", stalls); end
        checks++; if (stall_cnt !== CW'(exp_stall)) begin errors++; $display("FAIL sat_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL sat_sb_empty got=0 exp=entry"); end
            else begin
                e = sb.pop_front();
                if (RegWrite_wb !== e.rw || RegWriteAddr_wb !== e.addr || RegWriteData_wb !== e.data) begin
                    errors++;
                    $display("FAIL sat_wb got=%b/%0d/%h exp=%b/%0d/%h", RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, e.rw, e.addr, e.data);
                end
            end
        end
        mem_wait = 0;
    endtask

    task automatic test_align();
        wb_t e;
        @(negedge clk); mem_wait = 0; mem_rdata = 32'h0BAD_F00D;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h102, 32'h0, 32'h0BAD_F00D);
        @(negedge clk); bubble();
`ifdef DMEM_ALIGN_CHECK_EN
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL al_err got=%b exp=1", align_err); end
        checks++; if (dmem_req !== 1'b0 || Stall_mem !== 1'b0) begin errors++; $display("FAIL al_req got=%b%b exp=00", dmem_req, Stall_mem); end
`else
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL al_err got=%b exp=0", align_err); end
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h102) begin errors++; $display("FAIL al_req got=%b/%h exp=1/102", dmem_req, dmem_addr); end
`endif
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL al_sb_empty got=0 exp=entry"); end
            else begin
                e = sb.pop_front();
                if (RegWrite_wb !== e.rw || RegWriteAddr_wb !== e.addr || RegWriteData_wb !== e.data) begin
                    errors++;
                    $display("FAIL al_wb got=%b/%0d/%h exp=%b/%0d/%h", RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, e.rw, e.addr, e.data);
                end
            end
            if (k == 0) begin
                checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL al_err_clear got=%b exp=0", align_err); end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk); mem_wait = 5;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 32'h300, 32'h0, 32'h0);
        @(negedge clk); bubble();
        checks++; if (Stall_mem !== 1'b1) begin errors++; $display("FAIL rw_stall1 got=%b exp=1", Stall_mem); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b0 || Stall_mem !== 1'b0) begin errors++; $display("FAIL rw_req got=%b%b exp=00", dmem_req, Stall_mem); end
        checks++; if (RegWrite_mem !== 1'b0 || MemRead_mem !== 1'b0 || ALUResult_mem !== '0) begin errors++; $display("FAIL rw_mem got=%b/%b/%h exp=0/0/0", RegWrite_mem, MemRead_mem, ALUResult_mem); end
        checks++; if (RegWrite_wb !== 1'b0 || RegWriteData_wb !== '0 || RegWriteAddr_wb !== '0) begin errors++; $display("FAIL rw_wb got=%b/%h/%0d exp=0/0/0", RegWrite_wb, RegWriteData_wb, RegWriteAddr_wb); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL rw_cnt got=%0d exp=0", stall_cnt); end
        sb.delete();
        exp_stall = 0;
        mem_wait = 0;
        @(negedge clk); rst = 1'b0;
        bubble();
        sb.delete();
    endtask

    initial begin
        valid_ex = 1'b0; RegWriteAddr_ex = '0; ALUResult_ex = '0; MemWriteData_ex = '0;
        RegWrite_ex = 1'b0; MemRead_ex = 1'b0; MemWrite_ex = 1'b0; MemToReg_ex = 1'b0;
        test_reset();
        bubble();
        sb.delete();
        @(negedge clk);
        test_alu();
        test_load_zero_wait();
        test_store_wait();
        test_bubble();
        test_align();
        test_saturation();
        test_reset_mid_wait();
        test_alu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_module_mem_wb.md
Name: cpu_module_mem_wb

Overview:
- MEM stage plus the EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS pipeline.
- Captures EX results and performs the load/store on a req/ack data-memory port, stalling on wait states.
- Drives the forwarding sources consumed by the EX stage: the *_mem signals (one level) and the *_wb signals (two levels).
- RegWriteData_wb/RegWriteAddr_wb/RegWrite_wb also drive the register-file write port.

Parameters:
- DATA_W, 32, datapath and memory data width.
- REG_AW, 5, register address width.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- valid_ex  in  1  EX holds a real instruction; 0 = bubble
- RegWriteAddr_ex  in  REG_AW  destination register from EX
- ALUResult_ex  in  DATA_W  ALU result / memory address
- MemWriteData_ex  in  DATA_W  store data
- RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex  in  1 each  control from ID/EX
- dmem_req  out  1  memory access request
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_W  byte address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- dmem_ack  in  1  access complete this cycle
- RegWriteAddr_mem  out  REG_AW  EX/MEM destination (forwarding)
- RegWrite_mem  out  1  EX/MEM write enable (forwarding)
- ALUResult_mem  out  DATA_W  EX/MEM ALU result (forwarding)
- MemRead_mem  out  1  load in MEM, for the load-use hazard unit
- RegWriteAddr_wb  out  REG_AW  MEM/WB destination
- RegWrite_wb  out  1  MEM/WB write enable
- RegWriteData_wb  out  DATA_W  write-back data
- Stall_mem  out  1  freeze PC, IF/ID, ID/EX and this block's registers
- stall_cnt  out  CNT_W  saturating count of stall cycles
- align_err  out  1  see Optional Feature

Behaviour:
- Reset: asynchronous, active-high. While rst is asserted, all registered outputs are 0, the FSM is in IDLE, stall_cnt is 0, and dmem_req is deasserted immediately.
- EX/MEM register:
  - On each edge with Stall_mem=0, capture all EX inputs.
  - Control bits are ANDed with valid_ex, so a bubble has RegWrite/MemRead/MemWrite/MemToReg = 0.
  - Hold while Stall_mem=1.
- memop = MemRead_mem | MemWrite_mem.
- Memory port (combinational from EX/MEM): dmem_req = memop; dmem_we = MemWrite_mem; dmem_addr = ALUResult_mem; dmem_wdata = the registered store data.
- Stall_mem = memop & ~dmem_ack (combinational).
  - Zero-wait memory: ack arrives in the same cycle as the request, so there is no stall.
  - Non-memory instructions never stall.
- FSM:
  - IDLE -> WAIT when memop & ~dmem_ack.
  - WAIT stays while ~dmem_ack; dmem_req and address/data stay stable.
  - WAIT -> IDLE on dmem_ack, in the same cycle the pipeline advances.
  - IDLE with no memop stays IDLE.
- MEM/WB register:
  - On an edge with Stall_mem=0, capture RegWrite_wb = RegWrite_mem and RegWriteAddr_wb = RegWriteAddr_mem.
  - RegWriteData_wb = dmem_rdata if MemToReg_mem, else ALUResult_mem.
  - Hold during a stall; do not insert a bubble. Re-writing the same value is harmless and keeps the two-level forwarding path valid for a frozen EX instruction.
- Latency: non-memory instruction EX -> WB in 2 cycles; a memory op adds one cycle per wait state.
- Stores: RegWrite_ex is expected to be 0; the block does not override it.
- Register $0: writes pass through unfiltered; EX and the register file ignore them.
- RegWrite_mem is raw, not gated by MemRead. The hazard unit uses MemRead_mem to prevent forwarding of a load address.
- stall_cnt: +1 on every cycle with Stall_mem=1; saturates at all-ones; cleared only by rst.
- Reset during WAIT: the access is abandoned and the FSM returns to IDLE. The memory must tolerate a dropped request.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined:
  - A memop with ALUResult_mem[1:0] != 0 is flagged misaligned.
  - dmem_req is forced to 0 and Stall_mem to 0.
  - align_err is 1 for that cycle.
  - The captured RegWrite_wb is forced to 0 for that instruction.
  - The EX/MEM register advances normally.
- When undefined: align_err is tied to 0; the address passes through unchanged and alignment is the memory's responsibility.

Test Plan:
- ALU op: EX add, RegWriteAddr_ex=5, ALUResult_ex=0x0000_0010 -> next cycle RegWrite_mem=1, ALUResult_mem=0x10; following cycle RegWriteData_wb=0x10, RegWriteAddr_wb=5, RegWrite_wb=1.
- Zero-wait load: addr 0x100, ack in the same cycle with rdata 0xDEAD_BEEF -> Stall_mem never asserted; RegWriteData_wb=0xDEADBEEF one cycle later.
- 3-wait-state store: addr 0x200, wdata 0x1234_5678, ack on the 4th cycle -> Stall_mem high for 3 cycles with dmem_addr/dmem_wdata stable and MEM/WB held; stall_cnt=3; next instruction enters MEM on the cycle after ack.
- Bubble: valid_ex=0 with RegWrite_ex=1 -> RegWrite_mem=0, dmem_req=0.
- Reset mid-WAIT: assert rst during the 2nd wait cycle -> dmem_req, Stall_mem and all outputs 0 immediately; FSM is IDLE; stall_cnt=0.
- DMEM_ALIGN_CHECK_EN: load at 0x102 -> align_err=1 for 1 cycle, dmem_req=0, RegWrite_wb=0 for that instruction; without the macro, dmem_addr=0x102 and the request is issued.
